// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared definitions for the main control unit: RV32 opcode constants,
// branch funct3 codes, ALU operation classes and the bundled control word
// passed from the combinational decoder to the output register stage.
// -----------------------------------------------------------------------------
package control_pkg;

    // Major opcodes, instruction[6:0]
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;

    // Branch conditions, instruction[14:12]
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // ALU operation class handed to the ALU control stage
    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,  // address generation / link
        ALU_RTYPE  = 3'b001,  // ALU looks at funct3/funct7
        ALU_ITYPE  = 3'b010,  // ALU looks at funct3
        ALU_BRANCH = 3'b011,  // compare via subtract
        ALU_LUI    = 3'b100   // pass immediate through
    } alu_op_t;

    // Full control word. Mem_Read is not stored separately: it is by
    // definition a copy of mem_read_en, so it is derived at the output.
    typedef struct packed {
        logic    mem_read_en;
        logic    mem_to_reg;
        logic    mem_write_en;
        logic    alu_src;
        logic    reg_write;
        logic    beq;
        logic    bne;
        logic    jal_en;
        logic    jalr_en;
        alu_op_t alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decoder.sv
// -----------------------------------------------------------------------------
// control_decoder
// Purely combinational opcode/funct3 decode into a control word.
// Ports:
//   opcode [6:0] in  - instruction[6:0]
//   funct3 [2:0] in  - instruction[14:12]
//   ctrl         out - decoded control word (all zero for unknown opcodes)
// -----------------------------------------------------------------------------
module control_decoder
    import control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output ctrl_t      ctrl
);

    always_comb begin
        // Everything not explicitly set below stays 0, so unknown opcodes
        // fall out as a NOP without a separate branch.
        ctrl = CTRL_NOP;
        case (opcode)
            R_TYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_RTYPE;
            end
            I_TYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ITYPE;
            end
            LOAD: begin
                ctrl.mem_read_en = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_op      = ALU_ADD;
            end
            STORE: begin
                // Byte/word width is resolved in the memory stage, so all
                // store flavours share one decode.
                ctrl.mem_write_en = 1'b1;
                ctrl.alu_src      = 1'b1;
                ctrl.alu_op       = ALU_ADD;
            end
            BRANCH: begin
                // Only BEQ/BNE are supported; other conditions compare but
                // never take the branch.
                ctrl.alu_op = ALU_BRANCH;
                ctrl.beq    = (funct3 == F3_BEQ);
                ctrl.bne    = (funct3 == F3_BNE);
            end
            JAL: begin
                ctrl.jal_en    = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            JALR: begin
                ctrl.jalr_en   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_LUI;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Main pipeline control: combinational decode followed by one register
// stage, so every output reflects the opcode/funct3 sampled at the previous
// rising edge. Synchronous active-low reset forces a NOP.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   opcode[6:0], funct3   - instruction fields to decode
//   MemReadEn, MemToReg, MemWriteEn, ALUSrc, RegWrite,
//   BEQ, BNE, JALen, JALRen - registered control flags
//   Mem_Read              - load flag for hazard detection (== MemReadEn)
//   ALUop[2:0]            - ALU operation class
// -----------------------------------------------------------------------------
module control_unit
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic       MemReadEn,
    output logic       MemToReg,
    output logic       MemWriteEn,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic       BEQ,
    output logic       BNE,
    output logic       JALen,
    output logic       JALRen,
    output logic       Mem_Read,
    output logic [2:0] ALUop
);

    ctrl_t ctrl_next;
    ctrl_t ctrl_reg;

    control_decoder u_decoder (
        .opcode (opcode),
        .funct3 (funct3),
        .ctrl   (ctrl_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_reg <= CTRL_NOP;
        end else begin
            ctrl_reg <= ctrl_next;
        end
    end

    assign MemReadEn  = ctrl_reg.mem_read_en;
    assign MemToReg   = ctrl_reg.mem_to_reg;
    assign MemWriteEn = ctrl_reg.mem_write_en;
    assign ALUSrc     = ctrl_reg.alu_src;
    assign RegWrite   = ctrl_reg.reg_write;
    assign BEQ        = ctrl_reg.beq;
    assign BNE        = ctrl_reg.bne;
    assign JALen      = ctrl_reg.jal_en;
    assign JALRen     = ctrl_reg.jalr_en;
    // Same flop as MemReadEn, so the two can never disagree.
    assign Mem_Read   = ctrl_reg.mem_read_en;
    assign ALUop      = ctrl_reg.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Directed tests for control_unit. Outputs are packed into a 13-bit vector
// {MemReadEn, MemToReg, MemWriteEn, ALUSrc, RegWrite, BEQ, BNE, JALen,
//  JALRen, Mem_Read, ALUop[2:0]} and compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       MemReadEn, MemToReg, MemWriteEn, ALUSrc, RegWrite;
    logic       BEQ, BNE, JALen, JALRen, Mem_Read;
    logic [2:0] ALUop;

    int vectors;
    int miscompares;

    // Expected vectors, hand-written field by field:
    //                          MR MT MW AS RW BEQ BNE JAL JALR MRd ALUop
    localparam logic [12:0] EXP_NOP   = 13'b0_0_0_0_0_0_0_0_0_0_000;
    localparam logic [12:0] EXP_RTYPE = 13'b0_0_0_0_1_0_0_0_0_0_001;
    localparam logic [12:0] EXP_ITYPE = 13'b0_0_0_1_1_0_0_0_0_0_010;
    localparam logic [12:0] EXP_LOAD  = 13'b1_1_0_1_1_0_0_0_0_1_000;
    localparam logic [12:0] EXP_STORE = 13'b0_0_1_1_0_0_0_0_0_0_000;
    localparam logic [12:0] EXP_BEQ   = 13'b0_0_0_0_0_1_0_0_0_0_011;
    localparam logic [12:0] EXP_BNE   = 13'b0_0_0_0_0_0_1_0_0_0_011;
    localparam logic [12:0] EXP_BNONE = 13'b0_0_0_0_0_0_0_0_0_0_011;
    localparam logic [12:0] EXP_JAL   = 13'b0_0_0_1_1_0_0_1_0_0_000;
    localparam logic [12:0] EXP_JALR  = 13'b0_0_0_1_1_0_0_0_1_0_000;
    localparam logic [12:0] EXP_LUI   = 13'b0_0_0_1_1_0_0_0_0_0_100;

    control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .MemReadEn  (MemReadEn),
        .MemToReg   (MemToReg),
        .MemWriteEn (MemWriteEn),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .BEQ        (BEQ),
        .BNE        (BNE),
        .JALen      (JALen),
        .JALRen     (JALRen),
        .Mem_Read   (Mem_Read),
        .ALUop      (ALUop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] outs();
        return {MemReadEn, MemToReg, MemWriteEn, ALUSrc, RegWrite,
                BEQ, BNE, JALen, JALRen, Mem_Read, ALUop};
    endfunction

    // One rising edge, then settle so sampling is away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [6:0] op, input logic [2:0] f3);
        rst_n  = r;
        opcode = op;
        funct3 = f3;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        drive(1'b0, 7'h33, 3'b001);
        tick();
        obs = outs();
        vectors++;
        $display("reset     rst_n=0 op=%h f3=%b out=%b", opcode, funct3, obs);
        if (obs !== EXP_NOP) begin
            $display("FAIL reset_rtype: got %b expected %b", obs, EXP_NOP);
            miscompares++;
        end
    endtask

    task automatic test_rtype();
        logic [12:0] obs;
        drive(1'b1, 7'h33, 3'b001);
        tick();
        obs = outs();
        vectors++;
        $display("rtype     op=%h f3=%b out=%b", opcode, funct3, obs);
        if (obs !== EXP_RTYPE) begin
            $display("FAIL rtype: got %b expected %b", obs, EXP_RTYPE);
            miscompares++;
        end
        drive(1'b1, 7'h13, 3'b111);
        tick();
        obs = outs();
        vectors++;
        $display("itype     op=%h f3=%b out=%b", opcode, funct3, obs);
        if (obs !== EXP_ITYPE) begin
            $display("FAIL itype: got %b expected %b", obs, EXP_ITYPE);
            miscompares++;
        end
    endtask

    task automatic test_load_store();
        logic [12:0] obs;
        drive(1'b1, 7'h03, 3'b010);
        tick();
        obs = outs();
        vectors++;
        $display("load      op=%h f3=%b out=%b", opcode, funct3, obs);
        if (obs !== EXP_LOAD) begin
            $display("FAIL load: got %b expected %b", obs, EXP_LOAD);
            miscompares++;
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 7'h23, (i == 0) ? 3'b010 : 3'b000);
            tick();
            obs = outs();
            vectors++;
            $display("store     op=%h f3=%b out=%b", opcode, funct3, obs);
            if (obs !== EXP_STORE) begin
                $display("FAIL store_f3_%b: got %b expected %b", funct3, obs, EXP_STORE);
                miscompares++;
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3_tab  [3] = '{3'b000, 3'b001, 3'b100};
        logic [12:0] exp_tab [3] = '{EXP_BEQ, EXP_BNE, EXP_BNONE};
        logic [12:0] obs;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 7'h63, f3_tab[i]);
            tick();
            obs = outs();
            vectors++;
            $display("branch    op=%h f3=%b out=%b", opcode, funct3, obs);
            if (obs !== exp_tab[i]) begin
                $display("FAIL branch_f3_%b: got %b expected %b", funct3, obs, exp_tab[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_jumps_lui();
        logic [6:0]  op_tab  [3] = '{7'h6F, 7'h67, 7'h37};
        logic [12:0] exp_tab [3] = '{EXP_JAL, EXP_JALR, EXP_LUI};
        logic [12:0] obs;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, op_tab[i], 3'b101);
            tick();
            obs = outs();
            vectors++;
            $display("jump/lui  op=%h f3=%b out=%b", opcode, funct3, obs);
            if (obs !== exp_tab[i]) begin
                $display("FAIL op_%h: got %b expected %b", opcode, obs, exp_tab[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_unknown();
        logic [12:0] obs;
        drive(1'b1, 7'h7F, 3'b000);
        tick();
        obs = outs();
        vectors++;
        $display("unknown   op=%h f3=%b out=%b", opcode, funct3, obs);
        if (obs !== EXP_NOP) begin
            $display("FAIL unknown_7f: got %b expected %b", obs, EXP_NOP);
            miscompares++;
        end
    endtask

    // Inputs change mid-cycle: outputs must hold until the next edge.
    task automatic test_hold();
        logic [12:0] obs;
        drive(1'b1, 7'h33, 3'b000);
        tick();
        drive(1'b1, 7'h03, 3'b010);
        #3;
        obs = outs();
        vectors++;
        $display("hold      op=%h (pre-edge) out=%b", opcode, obs);
        if (obs !== EXP_RTYPE) begin
            $display("FAIL hold_before_edge: got %b expected %b", obs, EXP_RTYPE);
            miscompares++;
        end
        tick();
        obs = outs();
        vectors++;
        $display("hold      op=%h (post-edge) out=%b", opcode, obs);
        if (obs !== EXP_LOAD) begin
            $display("FAIL hold_after_edge: got %b expected %b", obs, EXP_LOAD);
            miscompares++;
        end
    endtask

    // Reset mid-stream discards the pending decode; first edge out of reset
    // registers whatever is on the inputs.
    task automatic test_midstream_reset();
        logic [12:0] obs;
        drive(1'b1, 7'h6F, 3'b000);
        tick();
        drive(1'b0, 7'h37, 3'b000);
        tick();
        obs = outs();
        vectors++;
        $display("midreset  rst_n=0 op=%h out=%b", opcode, obs);
        if (obs !== EXP_NOP) begin
            $display("FAIL midstream_reset: got %b expected %b", obs, EXP_NOP);
            miscompares++;
        end
        drive(1'b1, 7'h67, 3'b000);
        tick();
        obs = outs();
        vectors++;
        $display("release   op=%h out=%b", opcode, obs);
        if (obs !== EXP_JALR) begin
            $display("FAIL first_after_reset: got %b expected %b", obs, EXP_JALR);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        drive(1'b0, 7'h00, 3'b000);
        test_reset();
        test_rtype();
        test_load_store();
        test_branch();
        test_jumps_lui();
        test_unknown();
        test_hold();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
